// File: rtl/alu_serial_nbit.sv
// alu_serial_nbit
//   WIDTH-bit ALU built around a single 1-bit slice (AND/OR/XOR/full-add).
//   Operands are processed LSB-first, one bit per clock, so a result takes
//   WIDTH cycles. SUB is done as a + ~b + 1 through the same adder slice.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, cin, op        operands, carry-in (ADD only), opcode
//                        000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, else reserved
//   out_valid/out_ready  result handshake
//   result               operation result
//   cout, ovf            carry-out / signed overflow (ADD/SUB only)
//   zero                 result == 0
//   op_err               reserved opcode was issued
module alu_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             op_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             op_err_q, op_err_d;

  logic accept;
  logic last_bit;
  logic a_bit, b_bit, s_bit, c_out;
  logic is_arith;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_bit = (state_q == BUSY) && (cnt_q == CW'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------- bit slice ----------------
  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    c_out    = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    case (op_q)
      OP_AND:         s_bit = a_bit & b_bit;
      OP_OR:          s_bit = a_bit | b_bit;
      OP_XOR:         s_bit = a_bit ^ b_bit;
      OP_ADD, OP_SUB: s_bit = a_bit ^ b_bit ^ carry_q;
      default:        s_bit = 1'b0;  // reserved ops yield zero
    endcase
  end

  // ---------------- datapath next state ----------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    op_err_d = op_err_q;

    if (accept) begin
      a_d      = a;
      // SUB is a + ~b + 1: invert b here and seed the carry with 1
      b_d      = (op == OP_SUB) ? ~b : b;
      op_d     = op;
      carry_d  = (op == OP_ADD) ? cin : (op == OP_SUB);
      cnt_d    = '0;
      res_d    = '0;
      cout_d   = 1'b0;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
      op_err_d = 1'b0;
    end else if (state_q == BUSY) begin
      // LSB-first: new bit enters at the MSB, after WIDTH shifts bit 0 sits at the LSB
      res_d = {s_bit, res_q[WIDTH-1:1]};
      if (is_arith) carry_d = c_out;
      cnt_d = cnt_q + CW'(1);
      if (last_bit) begin
        cout_d   = is_arith & c_out;
        // carry_q is the carry into the MSB at this point
        ovf_d    = is_arith & (carry_q ^ c_out);
        zero_d   = (res_d == '0);
        op_err_d = (op_q > OP_SUB);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      op_err_q <= op_err_d;
    end
  end

  assign result = res_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign op_err = op_err_q;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Directed bench for alu_serial_nbit (WIDTH=8): hand-computed vectors for
// each op, flag corner cases, backpressure and reset abort.
module tb_alu_serial_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout, zero, ovf, op_err;

  int checks = 0;
  int errors = 0;

  alu_serial_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .ovf(ovf), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // wait for out_valid, counting edges; gives up after 100 edges
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic issue(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [2:0] top,
                       input logic [7:0] er, input logic ec, input logic ez,
                       input logic eo, input logic ee);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; cin = tc; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    // operands scrambled after acceptance so any late capture shows up
    in_valid = 1'b0; a = ~ta; b = ~tb; cin = ~tc; op = 3'b011;
    wait_done(n);
    chk({tag, ".latency"}, 64'(n), 64'd8);
    chk({tag, ".result"},  64'(result), 64'(er));
    chk({tag, ".cout"},    64'(cout),   64'(ec));
    chk({tag, ".zero"},    64'(zero),   64'(ez));
    chk({tag, ".ovf"},     64'(ovf),    64'(eo));
    chk({tag, ".op_err"},  64'(op_err), 64'(ee));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, ".in_ready_back"},  64'(in_ready),  64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = '0;
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.result",    64'(result),    64'd0);
    chk("rst.flags",     64'({cout, zero, ovf, op_err}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    //     tag        a      b      cin   op      result cout zero ovf err
    issue("add_ff01", 8'hFF, 8'h01, 1'b0, 3'b011, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); release_out("add_ff01");
    issue("add_7f01", 8'h7F, 8'h01, 1'b0, 3'b011, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0); release_out("add_7f01");
    issue("add_7fci", 8'h7F, 8'h00, 1'b1, 3'b011, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0); release_out("add_7fci");
    issue("sub_0507", 8'h05, 8'h07, 1'b0, 3'b100, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0); release_out("sub_0507");
    issue("sub_8001", 8'h80, 8'h01, 1'b0, 3'b100, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0); release_out("sub_8001");
    issue("sub_3333", 8'h33, 8'h33, 1'b1, 3'b100, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); release_out("sub_3333");
    issue("and",      8'hF0, 8'h3C, 1'b1, 3'b000, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0); release_out("and");
    issue("or",       8'hF0, 8'h3C, 1'b1, 3'b001, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0); release_out("or");
    issue("rsvd110",  8'hF0, 8'h3C, 1'b1, 3'b110, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1); release_out("rsvd110");

    // backpressure: hold DONE for 5 cycles while new operands are offered
    issue("xor", 8'hF0, 8'h3C, 1'b0, 3'b010, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; op = 3'b011; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.in_ready",  64'(in_ready),  64'd0);
      chk("bp.result",    64'(result),    64'hCC);
      chk("bp.flags",     64'({cout, zero, ovf, op_err}), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp.idle_out_valid", 64'(out_valid), 64'd0);
    chk("bp.idle_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;  // in_valid still high: this edge accepts 0x10+0x20
    in_valid = 1'b0; a = 8'hAA; b = 8'h55;
    chk("bp.accepted", 64'(in_ready), 64'd0);
    wait_done(n);
    chk("bp.next_latency", 64'(n), 64'd8);
    chk("bp.next_result",  64'(result), 64'h30);
    chk("bp.next_flags",   64'({cout, zero, ovf, op_err}), 64'd0);
    release_out("bp.next");

    // async reset while BUSY after 3 bits: 0x0F+0x0F has nonzero low bits
    @(negedge clk);
    a = 8'h0F; b = 8'h0F; cin = 1'b0; op = 3'b011; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.partial_nonzero", 64'(result != 0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.result",    64'(result),    64'd0);
    chk("abort.flags",     64'({cout, zero, ovf, op_err}), 64'd0);
    chk("abort.in_ready",  64'(in_ready),  64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", 8'h12, 8'h34, 1'b0, 3'b011, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_nbit.md
Name: alu_serial_nbit

Overview:
- WIDTH-bit ALU that reuses one 1-bit slice (AND/OR/XOR/full-add) and processes operands LSB-first, one bit per clock.
- Adds SUB, status flags (zero, carry, signed overflow) and valid/ready handshakes on input and output.
- Sits between the operand/op register stage and the result writeback. Trades latency (WIDTH cycles) for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used by ADD only
- op  in  3  000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101-111 reserved
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  operation result
- cout  out  1  carry-out (ADD/SUB), else 0
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD/SUB), else 0
- op_err  out  1  op was reserved

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; cout=0; zero=0; ovf=0; op_err=0; bit counter=0; carry reg=0.
  - in_ready = (state==IDLE), so it reads 1 while in reset.
  - Asserting reset at any point aborts any operation in flight; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid=1 at a clock edge, capture a, b, op, cin into internal registers and go to BUSY with counter=0.
    - Carry reg loads cin for ADD, 1 for SUB, 0 otherwise.
    - SUB stores ~b, so it computes a+~b+1; cin is ignored for SUB.
  - BUSY: in_ready=0. Each edge:
    - Compute slice(bit[counter]).
    - Shift the bit into the result shift register from the MSB side.
    - Update the carry reg (ADD/SUB only); counter++.
    - On the edge where counter==WIDTH-1: latch cout = final carry and ovf = carry-into-MSB XOR carry-out-of-MSB (ADD/SUB only), then go to DONE.
  - DONE: out_valid=1.
    - result, cout, zero, ovf and op_err are stable while out_valid=1 and out_ready=0.
    - zero is computed from the full registered result.
    - On out_ready=1 at an edge, out_valid drops and the block returns to IDLE.
- Reserved ops: result=0, zero=1, cout=0, ovf=0, op_err=1. Same latency as legal ops.
- Timing:
  - Latency: acceptance edge T; out_valid is high in the cycle after edge T+WIDTH.
  - Minimum issue interval: WIDTH+2 cycles (DONE->IDLE takes one edge, then acceptance).
- Flag polarity:
  - SUB carry is an inverted borrow: cout=1 means a>=b unsigned.
  - Logic ops always give cout=0 and ovf=0.
- Handshake and timing rules:
  - in_valid is ignored outside IDLE. Operands only need to be held until the acceptance edge.
  - out_ready outside DONE has no effect.
  - out_valid is registered; it is never driven combinationally from out_ready.
  - No combinational path from a, b, op or cin to any output.

Test Plan (WIDTH=8):
- ADD a=0xFF, b=0x01, cin=0 -> result=0x00, cout=1, zero=1, ovf=0, op_err=0. out_valid rises exactly 8 edges after acceptance.
- ADD a=0x7F, b=0x01, cin=0 -> 0x80, cout=0, ovf=1. Then ADD a=0x7F, b=0x00, cin=1 -> 0x80, ovf=1.
- SUB a=0x05, b=0x07 -> 0xFE, cout=0, ovf=0. SUB a=0x80, b=0x01 -> 0x7F, cout=1, ovf=1. SUB a=0x33, b=0x33, cin=1 -> 0x00, zero=1, cout=1 (cin ignored).
- AND/OR/XOR with a=0xF0, b=0x3C -> 0x30 / 0xFC / 0xCC; cout=0, ovf=0, zero=0. Reserved op=110 -> result=0x00, zero=1, op_err=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands driven -> outputs stable, in_ready=0, new operands not captured.
  - Then out_ready=1 -> IDLE next cycle; the following op is accepted and its result is correct.
- Drop rst_n while in BUSY after 3 bits -> out_valid=0 and all outputs 0 immediately, with no clock edge needed. After release, in_ready=1; the next ADD 0x12+0x34 -> 0x46 with no residue from the aborted op.
